// File: rtl/fine_dtc_with_decoder_pkg.sv
// Shared encodings, default widths and the fine-code clamp for the fine DTC.
package dtc_pkg;
  localparam int DEF_STAGES       = 256;
  localparam int DEF_FINE_BITS    = 8;
  localparam int DEF_COARSE_BITS  = 16;
  localparam int DEF_PULSE_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ARMED  = 3'd2,
    ST_COUNT  = 3'd3,
    ST_FIRE   = 3'd4
  } dtc_state_e;

  function automatic int unsigned clamp_fine(int unsigned v, int unsigned stages);
    return (v >= stages) ? stages - 1 : v;
  endfunction
endpackage

// File: rtl/fine_delay_line.sv
// Placed tapped delay line driven by the launch register; the only
// non-synchronous logic in the DTC. Each cell maps to one LUT/carry stage.
module dtc_delay_cell (
  input  logic i,
  output logic o
);
  assign o = i;
endmodule

module fine_delay_line #(
  parameter int STAGES = 256,
  parameter int Xoff   = 8,
  parameter int Yoff   = 24
) (
  input  logic              launch,
  output logic [STAGES-1:0] tap
);
  // Placement origin must lie on the device grid; the chain grows upward from it.
  if (Xoff >= 0 && Yoff >= 0) begin : g_line
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic d_in, d_out;
      if (k == 0) begin : g_head
        assign d_in = launch;
      end else begin : g_link
        assign d_in = g_stage[k-1].d_out;
      end
      (* keep *) dtc_delay_cell u_cell (.i(d_in), .o(d_out));
      assign tap[k] = d_out;
    end
  end
endmodule

// File: rtl/fine_dtc_with_decoder.sv
// Digital-to-time converter: coarse cycle counter plus fine tap select.
// Optional DTC_REPEAT_EN: FIRE returns to ARMED and keeps the loaded value.
module fine_dtc_with_decoder import dtc_pkg::*; #(
  parameter int STAGES       = DEF_STAGES,
  parameter int FINE_BITS    = DEF_FINE_BITS,
  parameter int COARSE_BITS  = DEF_COARSE_BITS,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int Xoff         = 8,
  parameter int Yoff         = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   value_valid,
  output logic                   value_ready,
  input  logic [COARSE_BITS-1:0] value_coarse,
  input  logic [FINE_BITS-1:0]   value_fine,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   pulse_out
);
`ifdef DTC_REPEAT_EN
  localparam logic REPEAT = 1'b1;
`else
  localparam logic REPEAT = 1'b0;
`endif

  dtc_state_e             state_q, state_d;
  logic [COARSE_BITS-1:0] coarse_q, coarse_d, cnt_q, cnt_d;
  logic [FINE_BITS-1:0]   fine_q, fine_d;
  logic [STAGES-1:0]      therm_q, therm_d, sel, tap;
  logic [3:0]             pcnt_q, pcnt_d;
  logic                   launch_q, launch_d, done_q, done_d;
  logic                   ready_q, ready_d, busy_q, busy_d;
  logic                   load;

  assign load = value_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    coarse_d = coarse_q;
    fine_d   = fine_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    launch_d = launch_q;
    done_d   = 1'b0;
    therm_d  = therm_q;
    // Thermometer only changes in DECODE, so the tap select is frozen while armed/firing.
    if (state_q == ST_DECODE)
      for (int k = 0; k < STAGES; k++) therm_d[k] = (k <= int'(fine_q));
    if (load) begin
      coarse_d = value_coarse;
      fine_d   = FINE_BITS'(clamp_fine(32'(value_fine), STAGES));
      state_d  = ST_DECODE;
    end else begin
      case (state_q)
        ST_DECODE: state_d = ST_ARMED;
        ST_ARMED: if (start) begin
          cnt_d   = coarse_q;
          state_d = ST_COUNT;
        end
        ST_COUNT: if (cnt_q == '0) begin
          launch_d = 1'b1;
          pcnt_d   = 4'(PULSE_CYCLES - 1);
          state_d  = ST_FIRE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        ST_FIRE: if (pcnt_q == '0) begin
          launch_d = 1'b0;
          done_d   = 1'b1;
          state_d  = REPEAT ? ST_ARMED : ST_IDLE;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ready_d = (state_d == ST_IDLE) | (REPEAT & (state_d == ST_ARMED));
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      coarse_q <= '0;
      fine_q   <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      launch_q <= 1'b0;
      done_q   <= 1'b0;
      therm_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      coarse_q <= coarse_d;
      fine_q   <= fine_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      launch_q <= launch_d;
      done_q   <= done_d;
      therm_q  <= therm_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // One-hot edge of the thermometer: sel[k] = therm[k] & ~therm[k+1].
  assign sel = therm_q & ~{1'b0, therm_q[STAGES-1:1]};

  fine_delay_line #(.STAGES(STAGES), .Xoff(Xoff), .Yoff(Yoff)) u_line (
    .launch (launch_q),
    .tap    (tap)
  );

  assign pulse_out   = |(tap & sel);
  assign value_ready = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_fine_dtc_with_decoder.sv
// Directed bench for fine_dtc_with_decoder (STAGES=200 so the fine clamp is reachable).
module tb_fine_dtc_with_decoder;
  localparam int STAGES = 200, FINE_BITS = 8, COARSE_BITS = 16, PULSE_CYCLES = 2;

  logic clk, rst_n, value_valid, value_ready, start, busy, done, pulse_out;
  logic [COARSE_BITS-1:0] value_coarse;
  logic [FINE_BITS-1:0]   value_fine;
  int cyc = 0;
  int n_chk = 0, n_pass = 0;

  fine_dtc_with_decoder #(
    .STAGES(STAGES), .FINE_BITS(FINE_BITS), .COARSE_BITS(COARSE_BITS),
    .PULSE_CYCLES(PULSE_CYCLES), .Xoff(8), .Yoff(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value_valid(value_valid), .value_ready(value_ready),
    .value_coarse(value_coarse), .value_fine(value_fine), .start(start),
    .busy(busy), .done(done), .pulse_out(pulse_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int onehot_idx(input logic [STAGES-1:0] v);
    int idx = -1;
    if ($countones(v) != 1) return -1;
    for (int k = 0; k < STAGES; k++) if (v[k]) idx = k;
    return idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int c, input int f);
    value_coarse = COARSE_BITS'(c);
    value_fine   = FINE_BITS'(f);
    value_valid  = 1'b1;
    tick();
    value_valid  = 1'b0;
  endtask

  // Start at edge S, then time the launch rise and the done edge relative to S.
  task automatic start_and_time(input string tag, input int exp_rise, input int exp_done,
                                input int exp_idx);
    int s;
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    while (!pulse_out && (cyc - s) < 200) tick();
    chk({tag, "_rise"}, 32'(cyc - s), 32'(exp_rise));
    chk({tag, "_sel"}, 32'(onehot_idx(dut.sel)), 32'(exp_idx));
    while (!done && (cyc - s) < 300) tick();
    chk({tag, "_done"}, 32'(cyc - s), 32'(exp_done));
    chk({tag, "_ready"}, 32'(value_ready), 32'd1);
    chk({tag, "_fall"}, 32'(pulse_out), 32'd0);
    tick();
    chk({tag, "_done1"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; value_valid = 1'b0; start = 1'b0; value_coarse = '0; value_fine = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(value_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pulse", 32'(pulse_out), 32'd0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    rst_n = 1'b1;
    tick();

`ifdef DTC_REPEAT_EN
    load(3, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      start_and_time("rep", 4, 6, 0);
      chk("rep_armed_busy", 32'(busy), 32'd1);
      repeat (3) tick();
    end
    chk("rep_reload_ready", 32'(value_ready), 32'd1);
    load(1, 0);
    tick();
    start_and_time("rep_reload", 2, 4, 0);
`else
    // coarse=5, fine=0
    load(5, 0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(value_ready), 32'd0);
    tick();
    start_and_time("t1", 6, 8, 0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // coarse=0, fine=100
    load(0, 100);
    tick();
    start_and_time("t2", 1, 3, 100);

    // fine clamp plus a start during DECODE that must be ignored
    value_coarse = 16'd7; value_fine = 8'd250; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("t3_armed", 32'(dut.state_q), 32'd2);
    chk("t3_nopulse", 32'(pulse_out), 32'd0);
    start_and_time("t3", 8, 10, 199);

    // new value offered while busy: held off until after done
    load(3, 10);
    tick();
    value_coarse = 16'd20; value_fine = 8'd5; value_valid = 1'b1;
    chk("t4_ready_armed", 32'(value_ready), 32'd0);
    start_and_time("t4", 4, 6, 10);
    value_valid = 1'b0;
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_coarse", 32'(dut.coarse_q), 32'd20);
    tick();
    start_and_time("t5", 21, 23, 5);
`endif

    // asynchronous reset in the middle of FIRE
    load(2, 50);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("t6_rise", 32'(pulse_out), 32'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pulse", 32'(pulse_out), 32'd0);
    chk("t6_launch", 32'(dut.launch_q), 32'd0);
    chk("t6_ready", 32'(value_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_nodone", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_ready2", 32'(value_ready), 32'd1);
    chk("t6_done2", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
